// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send, then
// shifts one command byte out on device-generated clock falls and checks the ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int SETUP_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       err_noack,
    output logic       err_timeout
);
    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE} state_t;

    localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] SETUP_LAST   = 20'(SETUP_CYCLES - 1);
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [19:0] cnt;
    logic [9:0]  shift;
    logic [3:0]  idx;
    logic        clk_p0, clk_p1, clk_p2;
    logic        dat_p0, dat_p1;
    logic        fall;

    // Synchronizers reset to the idle-high bus level so reset never fakes a fall
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            clk_p0 <= 1'b1;
            clk_p1 <= 1'b1;
            clk_p2 <= 1'b1;
            dat_p0 <= 1'b1;
            dat_p1 <= 1'b1;
        end else begin
            clk_p0 <= ps2_clk_in;
            clk_p1 <= clk_p0;
            clk_p2 <= clk_p1;
            dat_p0 <= ps2_dat_in;
            dat_p1 <= dat_p0;
        end
    end

    assign fall = clk_p2 & ~clk_p1;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            shift       <= '0;
            idx         <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_dat_oe  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_noack   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        shift       <= {1'b1, ~^tx_data, tx_data};
                        err_noack   <= 1'b0;
                        err_timeout <= 1'b0;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        ps2_clk_oe  <= 1'b1;
                        ps2_dat_oe  <= 1'b0;
                        state       <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt == INHIBIT_LAST) begin
                        cnt        <= '0;
                        ps2_dat_oe <= 1'b1;
                        state      <= RTS;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                RTS: begin
                    if (cnt == SETUP_LAST) begin
                        cnt        <= '0;
                        idx        <= '0;
                        ps2_clk_oe <= 1'b0;
                        state      <= SEND;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                SEND, ACK, WAIT_IDLE: begin
                    // A fall always restarts the gap counter, even on the expiry cycle
                    if (fall) cnt <= '0;
                    else      cnt <= cnt + 20'd1;

                    if (state == SEND && fall) begin
                        ps2_dat_oe <= ~shift[0];
                        shift      <= shift >> 1;
                        idx        <= idx + 4'd1;
                        if (idx == 4'd9) state <= ACK;
                    end else if (state == ACK && fall) begin
                        err_noack <= dat_p1;
                        state     <= WAIT_IDLE;
                    end else if (state == WAIT_IDLE && clk_p1 && dat_p1) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (!fall && cnt == TIMEOUT_LAST) begin
                        err_timeout <= 1'b1;
                        ps2_clk_oe  <= 1'b0;
                        ps2_dat_oe  <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model and a
// scoreboard of expected frames and error flags.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH  = 60;
    localparam int SET  = 5;
    localparam int TO   = 2000;
    localparam int HALF = 20;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       ps2_clk_oe, ps2_dat_oe, busy, done, err_noack, err_timeout;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       clk_pin, dat_pin;

    assign clk_pin = ~(ps2_clk_oe | dev_clk_low);
    assign dat_pin = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .SETUP_CYCLES  (SET),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .ps2_clk_in (clk_pin),
        .ps2_dat_in (dat_pin),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .err_noack  (err_noack),
        .err_timeout(err_timeout)
    );

    always #10 Clk = ~Clk;

    typedef struct {
        logic [9:0] frame;
        logic       chk_frame;
        logic       noack;
        logic       tout;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   done_cnt = 0;

    always @(negedge Clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic start(input logic [7:0] d, input string tag);
        @(negedge Clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge Clk);
        tx_start = 1'b0;
        chk({tag, " busy on accept"}, busy, 1);
        chk({tag, " clk_oe on accept"}, ps2_clk_oe, 1);
        chk({tag, " noack cleared"}, err_noack, 0);
        chk({tag, " timeout cleared"}, err_timeout, 0);
    endtask

    // Counts inhibit (clock low only) and setup (both low) cycles until clock release
    task automatic rts_phase(input string tag);
        int ni, ns;
        bit ended;
        ni = 1; ns = 0; ended = 1'b0;
        for (int g = 0; g < INH + SET + 20; g++) begin
            @(negedge Clk);
            if (ps2_clk_oe && !ps2_dat_oe) ni++;
            else if (ps2_clk_oe && ps2_dat_oe) ns++;
            else begin
                ended = 1'b1;
                break;
            end
        end
        chk({tag, " clk released"}, ended, 1);
        chk({tag, " inhibit cycles"}, ni, INH);
        chk({tag, " setup cycles"}, ns, SET);
        chk({tag, " start bit held"}, ps2_dat_oe, 1);
    endtask

    // Device: nfalls clocks; bit n sampled at end of low phase; clock 11 carries ACK
    task automatic dev_frame(input int nfalls, input bit ack, input int poke,
                             output logic [9:0] bits);
        bits = '0;
        repeat (10) @(negedge Clk);
        for (int n = 1; n <= nfalls && n <= 11; n++) begin
            if (n == 11) dev_dat_low = ack;
            dev_clk_low = 1'b1;
            if (n == poke) begin
                tx_data  = 8'h55;
                tx_start = 1'b1;
                @(negedge Clk);
                tx_start = 1'b0;
                repeat (HALF - 1) @(negedge Clk);
            end else begin
                repeat (HALF) @(negedge Clk);
            end
            if (n <= 10) bits[n-1] = dat_pin;
            dev_clk_low = 1'b0;
            if (n == 11) dev_dat_low = 1'b0;
            else repeat (HALF) @(negedge Clk);
        end
    endtask

    task automatic wait_done(input logic [9:0] got, input string tag);
        exp_t e;
        int   k;
        e = '{frame: 10'h0, chk_frame: 1'b0, noack: 1'b0, tout: 1'b0};
        k = 0;
        while (done !== 1'b1 && k < TO + 200) begin
            @(negedge Clk);
            k++;
        end
        chk({tag, " done seen"}, done, 1);
        chk({tag, " scoreboard depth"}, sb.size(), 1);
        if (sb.size() > 0) e = sb.pop_front();
        if (e.chk_frame) chk({tag, " frame"}, got, e.frame);
        chk({tag, " err_noack"}, err_noack, e.noack);
        chk({tag, " err_timeout"}, err_timeout, e.tout);
        chk({tag, " busy with done"}, busy, 0);
        chk({tag, " lines released"}, {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        @(negedge Clk);
        chk({tag, " done one cycle"}, done, 0);
    endtask

    logic [9:0] bits;
    int         k;
    int         d0;

    initial begin
        repeat (3) @(negedge Clk);
        chk("reset clk_oe", ps2_clk_oe, 0);
        chk("reset dat_oe", ps2_dat_oe, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset noack", err_noack, 0);
        chk("reset timeout", err_timeout, 0);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);

        sb.push_back('{frame: 10'h3ED, chk_frame: 1'b1, noack: 1'b0, tout: 1'b0});
        start(8'hED, "ed");
        rts_phase("ed");
        dev_frame(11, 1'b1, 0, bits);
        wait_done(bits, "ed");

        sb.push_back('{frame: 10'h2F4, chk_frame: 1'b1, noack: 1'b0, tout: 1'b0});
        start(8'hF4, "f4");
        rts_phase("f4");
        dev_frame(11, 1'b1, 0, bits);
        wait_done(bits, "f4");

        sb.push_back('{frame: 10'h300, chk_frame: 1'b1, noack: 1'b0, tout: 1'b0});
        start(8'h00, "00");
        rts_phase("00");
        dev_frame(11, 1'b1, 0, bits);
        wait_done(bits, "00");

        sb.push_back('{frame: 10'h3FF, chk_frame: 1'b1, noack: 1'b1, tout: 1'b0});
        start(8'hFF, "ff_noack");
        rts_phase("ff_noack");
        dev_frame(11, 1'b0, 0, bits);
        wait_done(bits, "ff_noack");
        repeat (5) @(negedge Clk);
        chk("noack held", err_noack, 1);

        // Device that never clocks; start() also confirms err_noack clears on accept
        sb.push_back('{frame: 10'h0, chk_frame: 1'b0, noack: 1'b0, tout: 1'b1});
        start(8'h3C, "tout");
        rts_phase("tout");
        k = 0;
        while (done !== 1'b1 && k < TO + 100) begin
            @(negedge Clk);
            k++;
        end
        chk("timeout latency", k, TO);
        wait_done(10'h0, "tout");

        start(8'h00, "rst");
        rts_phase("rst");
        dev_frame(3, 1'b1, 0, bits);
        dev_clk_low = 1'b1;
        repeat (5) @(negedge Clk);
        chk("rst dat_oe before reset", ps2_dat_oe, 1);
        chk("rst busy before reset", busy, 1);
        #3 Reset = 1'b1;
        #1;
        chk("rst async clk_oe", ps2_clk_oe, 0);
        chk("rst async dat_oe", ps2_dat_oe, 0);
        chk("rst async busy", busy, 0);
        dev_clk_low = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);

        sb.push_back('{frame: 10'h3ED, chk_frame: 1'b1, noack: 1'b0, tout: 1'b0});
        start(8'hED, "ed_after_rst");
        rts_phase("ed_after_rst");
        dev_frame(11, 1'b1, 0, bits);
        wait_done(bits, "ed_after_rst");

        d0 = done_cnt;
        sb.push_back('{frame: 10'h3ED, chk_frame: 1'b1, noack: 1'b0, tout: 1'b0});
        start(8'hED, "ed_poke");
        rts_phase("ed_poke");
        dev_frame(11, 1'b1, 5, bits);
        wait_done(bits, "ed_poke");
        repeat (20) @(negedge Clk);
        chk("poke single done", done_cnt - d0, 1);
        chk("poke stays idle", busy, 0);
        chk("poke clk_oe idle", ps2_clk_oe, 0);
        chk("poke scoreboard empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
